global_buffer: RTL and testbench

Global buffer (GLB) storage block: the buffer-side responder of the global-buffer data and control interfaces. It holds `bufferDepth` words of `interfaceDepth*dataSize` bits. It accepts streamed writes from the outside (DMA/testbench) into weight, activation, or output regions, and streams activation words back out on command. It executes one `global_buffer_instruction_t` at a time and sits between the off-chip loader and the PE-array feeders.

---
 rtl/global_buffer.sv | 150 +++++++++++++++
 tb/tb_global_buffer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_buffer.sv
// Global buffer storage: streams writes into weight/activation/output regions and
// streams activation words back out, one instruction at a time.
module global_buffer #(
    parameter int unsigned dataSize       = 8,
    parameter int unsigned interfaceDepth = 16,
    parameter int unsigned addrWidth      = 32,
    parameter int unsigned bufferDepth    = 64,
    localparam int unsigned W             = interfaceDepth * dataSize,
    localparam int unsigned AW            = $clog2(bufferDepth)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [3:0]           instr_i,
    input  logic                 instr_valid_i,
    input  logic [AW:0]          len_i,
    input  logic [addrWidth-1:0] weight_start_addr_i,
    input  logic [addrWidth-1:0] activation_start_addr_i,
    input  logic [W-1:0]         wr_data_i,
    input  logic                 wr_en_i,
    output logic                 ready_o,
    output logic [W-1:0]         rd_data_o,
    output logic                 rd_data_valid_o,
    output logic                 busy_o
);

    localparam logic [3:0] I_NOP             = 4'd0;
    localparam logic [3:0] I_POINTER_RESET   = 4'd1;
    localparam logic [3:0] I_LOAD_WEIGHT     = 4'd2;
    localparam logic [3:0] I_LOAD_ACTIVATION = 4'd3;
    localparam logic [3:0] I_LOAD_OUTPUT     = 4'd4;
    localparam logic [3:0] I_READ_ACTIVATION = 4'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_READ = 2'd2;

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [1:0]    r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic [W-1:0]  r_rd_data;
    logic          r_rd_valid;
    logic [W-1:0]  r_mem [bufferDepth];

    logic [1:0]    w_state_d;
    logic [AW-1:0] w_wr_ptr_d;
    logic [AW-1:0] w_rd_ptr_d;
    logic [AW:0]   w_cnt_d;
    logic          w_mem_we;
    logic          w_rd_issue;
    logic          w_len_nz;
    logic [AW-1:0] w_weight_base;
    logic [AW-1:0] w_act_base;
    logic          w_unused_addr_bits;

    assign w_weight_base = weight_start_addr_i[AW-1:0];
    assign w_act_base    = activation_start_addr_i[AW-1:0];
    assign w_len_nz      = |len_i;

    // Only the low AW address bits index the buffer.
    assign w_unused_addr_bits = ^{weight_start_addr_i[addrWidth-1:AW],
                                  activation_start_addr_i[addrWidth-1:AW]};

    assign w_mem_we   = (r_state == ST_LOAD) && wr_en_i && nrst;
    assign w_rd_issue = (r_state == ST_READ);

    always_comb begin
        w_state_d  = r_state;
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_cnt_d    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (instr_valid_i) begin
                    case (instr_i)
                        I_POINTER_RESET: begin
                            w_wr_ptr_d = '0;
                            w_rd_ptr_d = w_act_base;
                        end
                        I_LOAD_WEIGHT: begin
                            w_wr_ptr_d = w_weight_base;
                            w_cnt_d    = len_i;
                            if (w_len_nz) w_state_d = ST_LOAD;
                        end
                        I_LOAD_ACTIVATION: begin
                            w_wr_ptr_d = w_act_base;
                            w_cnt_d    = len_i;
                            if (w_len_nz) w_state_d = ST_LOAD;
                        end
                        I_LOAD_OUTPUT: begin
                            w_cnt_d = len_i;
                            if (w_len_nz) w_state_d = ST_LOAD;
                        end
                        I_READ_ACTIVATION: begin
                            w_rd_ptr_d = w_act_base;
                            w_cnt_d    = len_i;
                            if (w_len_nz) w_state_d = ST_READ;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (wr_en_i) begin
                    w_wr_ptr_d = r_wr_ptr + 1'b1;
                    w_cnt_d    = r_cnt - 1'b1;
                    if (r_cnt == CNT_ONE) w_state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                w_rd_ptr_d = r_rd_ptr + 1'b1;
                w_cnt_d    = r_cnt - 1'b1;
                if (r_cnt == CNT_ONE) w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wr_ptr   <= w_wr_ptr_d;
            r_rd_ptr   <= w_rd_ptr_d;
            r_cnt      <= w_cnt_d;
            r_rd_valid <= w_rd_issue;
            // Read data holds its last value between bursts.
            if (w_rd_issue) r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_wr_ptr] <= wr_data_i;
    end

    assign ready_o         = (r_state == ST_LOAD);
    assign busy_o          = (r_state != ST_IDLE);
    assign rd_data_o       = r_rd_data;
    assign rd_data_valid_o = r_rd_valid;

endmodule

// File: tb/tb_global_buffer.sv
// Directed self-checking bench for global_buffer: loads, readback, wrap, ignored inputs,
// output append and reset in the middle of a read.
module tb_global_buffer;

    localparam int unsigned AW = 6;
    localparam int unsigned W  = 128;

    localparam logic [3:0] I_NOP             = 4'd0;
    localparam logic [3:0] I_POINTER_RESET   = 4'd1;
    localparam logic [3:0] I_LOAD_WEIGHT     = 4'd2;
    localparam logic [3:0] I_LOAD_ACTIVATION = 4'd3;
    localparam logic [3:0] I_LOAD_OUTPUT     = 4'd4;
    localparam logic [3:0] I_READ_ACTIVATION = 4'd5;

    logic          clk;
    logic          nrst;
    logic [3:0]    instr_i;
    logic          instr_valid_i;
    logic [AW:0]   len_i;
    logic [31:0]   weight_start_addr_i;
    logic [31:0]   activation_start_addr_i;
    logic [W-1:0]  wr_data_i;
    logic          wr_en_i;
    logic          ready_o;
    logic [W-1:0]  rd_data_o;
    logic          rd_data_valid_o;
    logic          busy_o;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];

    global_buffer dut (
        .clk                     (clk),
        .nrst                    (nrst),
        .instr_i                 (instr_i),
        .instr_valid_i           (instr_valid_i),
        .len_i                   (len_i),
        .weight_start_addr_i     (weight_start_addr_i),
        .activation_start_addr_i (activation_start_addr_i),
        .wr_data_i               (wr_data_i),
        .wr_en_i                 (wr_en_i),
        .ready_o                 (ready_o),
        .rd_data_o               (rd_data_o),
        .rd_data_valid_o         (rd_data_valid_o),
        .busy_o                  (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input int len);
        instr_i       = op;
        len_i         = (AW+1)'(len);
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        instr_i       = I_NOP;
    endtask

    // Streams exp_q into the buffer, optionally holding wr_en low before word stall_at.
    task automatic load(input string tag, input logic [3:0] op, input int stall_at,
                        input int stall_n);
        issue(op, exp_q.size());
        check1({tag, "_ready_on"}, ready_o, 1'b1);
        check1({tag, "_busy_on"}, busy_o, 1'b1);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == stall_at) begin
                wr_en_i = 1'b0;
                for (int s = 0; s < stall_n; s++) tick();
                check1({tag, "_ready_stall"}, ready_o, 1'b1);
            end
            wr_en_i   = 1'b1;
            wr_data_i = exp_q[i];
            tick();
        end
        wr_en_i = 1'b0;
        check1({tag, "_ready_off"}, ready_o, 1'b0);
        check1({tag, "_busy_off"}, busy_o, 1'b0);
    endtask

    // Reads exp_q.size() words from addr and expects them on consecutive cycles.
    task automatic read_check(input string tag, input logic [AW-1:0] addr);
        int n;
        n = exp_q.size();
        activation_start_addr_i = 32'(addr);
        issue(I_READ_ACTIVATION, n);
        check1({tag, "_lat_valid"}, rd_data_valid_o, 1'b0);
        check1({tag, "_busy"}, busy_o, 1'b1);
        tick();
        for (int i = 0; i < n; i++) begin
            check1({tag, "_valid"}, rd_data_valid_o, 1'b1);
            check({tag, "_data"}, rd_data_o, exp_q[i]);
            if (i == n - 1) check1({tag, "_last_idle"}, busy_o, 1'b0);
            tick();
        end
        check1({tag, "_valid_off"}, rd_data_valid_o, 1'b0);
        check({tag, "_hold"}, rd_data_o, exp_q[n-1]);
    endtask

    initial begin
        nrst                    = 1'b0;
        instr_i                 = I_NOP;
        instr_valid_i           = 1'b0;
        len_i                   = '0;
        weight_start_addr_i     = '0;
        activation_start_addr_i = '0;
        wr_data_i               = '0;
        wr_en_i                 = 1'b0;
        tick();
        tick();
        check1("rst_ready", ready_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_valid", rd_data_valid_o, 1'b0);
        check("rst_data", rd_data_o, '0);
        nrst = 1'b1;
        tick();

        // Weight load with a 2-cycle stall before the third word.
        weight_start_addr_i = 32'd4;
        exp_q.delete();
        exp_q.push_back(128'hA);
        exp_q.push_back(128'hB);
        exp_q.push_back(128'hC);
        load("wload", I_LOAD_WEIGHT, 2, 2);
        read_check("wread", 6'd4);

        // Activation load and readback.
        activation_start_addr_i = 32'd10;
        exp_q.delete();
        exp_q.push_back(128'h1111_2222_3333_4444_5555_6666_7777_8888);
        exp_q.push_back(128'hDEAD_BEEF);
        exp_q.push_back({16{8'h5A}});
        exp_q.push_back({16{8'hA5}});
        load("aload", I_LOAD_ACTIVATION, -1, 0);
        read_check("aread", 6'd10);

        // Wrap-around through the top of the buffer.
        activation_start_addr_i = 32'd62;
        exp_q.delete();
        exp_q.push_back(128'hD0);
        exp_q.push_back(128'hD1);
        exp_q.push_back(128'hD2);
        exp_q.push_back(128'hD3);
        load("wrapload", I_LOAD_ACTIVATION, -1, 0);
        read_check("wrapread", 6'd62);
        exp_q.delete();
        exp_q.push_back(128'hD2);
        exp_q.push_back(128'hD3);
        read_check("wraplow", 6'd0);

        // Instruction while busy is ignored.
        weight_start_addr_i = 32'd20;
        issue(I_LOAD_WEIGHT, 2);
        activation_start_addr_i = 32'd40;
        instr_i       = I_READ_ACTIVATION;
        len_i         = 7'd5;
        instr_valid_i = 1'b1;
        tick();
        instr_valid_i = 1'b0;
        check1("busy_ign_ready", ready_o, 1'b1);
        check1("busy_ign_valid", rd_data_valid_o, 1'b0);
        wr_en_i   = 1'b1;
        wr_data_i = 128'hE0;
        tick();
        wr_data_i = 128'hE1;
        tick();
        wr_en_i = 1'b0;
        check1("busy_ign_done", busy_o, 1'b0);
        exp_q.delete();
        exp_q.push_back(128'hE0);
        exp_q.push_back(128'hE1);
        read_check("busy_ign_read", 6'd20);

        // wr_en in IDLE after pointer reset must not touch address 0.
        activation_start_addr_i = 32'd0;
        issue(I_POINTER_RESET, 0);
        check1("ptrrst_busy", busy_o, 1'b0);
        wr_en_i   = 1'b1;
        wr_data_i = 128'hBAD;
        tick();
        tick();
        wr_en_i = 1'b0;
        check1("idle_wr_ready", ready_o, 1'b0);
        check1("idle_wr_valid", rd_data_valid_o, 1'b0);
        exp_q.delete();
        exp_q.push_back(128'hD2);
        exp_q.push_back(128'hD3);
        read_check("idle_wr_read", 6'd0);

        // Zero length, NOP and undefined opcodes leave the block idle.
        weight_start_addr_i = 32'd30;
        issue(I_LOAD_WEIGHT, 0);
        check1("len0_load_busy", busy_o, 1'b0);
        check1("len0_load_ready", ready_o, 1'b0);
        issue(I_READ_ACTIVATION, 0);
        check1("len0_read_busy", busy_o, 1'b0);
        tick();
        check1("len0_read_valid", rd_data_valid_o, 1'b0);
        issue(I_NOP, 3);
        check1("nop_busy", busy_o, 1'b0);
        issue(4'hF, 3);
        check1("undef_busy", busy_o, 1'b0);
        tick();
        check1("undef_valid", rd_data_valid_o, 1'b0);

        // Output append: two loads continue from the reset write pointer.
        issue(I_POINTER_RESET, 0);
        exp_q.delete();
        exp_q.push_back(128'hF0);
        exp_q.push_back(128'hF1);
        load("out1", I_LOAD_OUTPUT, -1, 0);
        exp_q.delete();
        exp_q.push_back(128'hF2);
        exp_q.push_back(128'hF3);
        load("out2", I_LOAD_OUTPUT, 1, 1);
        exp_q.delete();
        exp_q.push_back(128'hF0);
        exp_q.push_back(128'hF1);
        exp_q.push_back(128'hF2);
        exp_q.push_back(128'hF3);
        read_check("outread", 6'd0);

        // Reset in the middle of an 8-word read.
        activation_start_addr_i = 32'd40;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(128'h100 + 128'(i));
        load("rload", I_LOAD_ACTIVATION, -1, 0);
        issue(I_READ_ACTIVATION, 8);
        tick();
        tick();
        check1("mid_valid", rd_data_valid_o, 1'b1);
        check("mid_data", rd_data_o, 128'h101);
        tick();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check1("midrst_valid", rd_data_valid_o, 1'b0);
        check1("midrst_busy", busy_o, 1'b0);
        check1("midrst_ready", ready_o, 1'b0);
        check("midrst_data", rd_data_o, '0);
        tick();
        check1("midrst_valid2", rd_data_valid_o, 1'b0);
        read_check("reread", 6'd40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
